// File: rtl/audio_mem_pkg.sv
// Shared mode/state encodings and default widths for the audio RAM sequencer.
package audio_mem_pkg;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_ADDR_W   = 26;
  localparam int DEF_OVR_W    = 8;

  // Channel index is wide enough for up to 8 channels plus headroom.
  localparam int CH_IDX_W = 4;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_REC  = 2'd1,
    MODE_PLAY = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_WR         = 3'd2,
    S_RD_REQ     = 3'd3,
    S_RD_WAIT    = 3'd4,
    S_RD_ACK     = 3'd5
  } state_t;

endpackage

// File: rtl/audio_ram_sequencer_frame_buffer.sv
// CHANNELS x SAMPLE_W register array: whole-frame load for recording,
// per-channel indexed write for the playback shadow, parallel frame read.
module frame_buffer
  import audio_mem_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         load_all,
  input  logic [CHANNELS*SAMPLE_W-1:0] frame_in,
  input  logic                         wr_en,
  input  logic [CH_IDX_W-1:0]          wr_idx,
  input  logic [SAMPLE_W-1:0]          wr_data,
  input  logic [CH_IDX_W-1:0]          rd_idx,
  output logic [SAMPLE_W-1:0]          rd_data,
  output logic [CHANNELS*SAMPLE_W-1:0] frame_out
);

  logic [SAMPLE_W-1:0] slots [CHANNELS];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < CHANNELS; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load_all) begin
          slots[i] <= frame_in[i*SAMPLE_W +: SAMPLE_W];
        end else if (wr_en && (wr_idx == CH_IDX_W'(i))) begin
          slots[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_idx == CH_IDX_W'(i)) rd_data = slots[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign frame_out[g*SAMPLE_W +: SAMPLE_W] = slots[g];
  end

endmodule

// File: rtl/audio_ram_sequencer.sv
// Record/playback sequencer moving multi-channel audio frames between the
// codec sample path and the memory interface user port.
module audio_ram_sequencer
  import audio_mem_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OVR_W    = DEF_OVR_W
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [1:0]                   mode,
  input  logic                         loop_en,
  input  logic                         addr_clr,
  input  logic [ADDR_W-1:0]            end_addr,
  input  logic                         sample_end,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_samples,
  output logic [CHANNELS*SAMPLE_W-1:0] out_samples,
  output logic                         out_valid,
  input  logic                         mem_rdy,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [SAMPLE_W-1:0]          mem_wdata,
  output logic                         mem_we,
  output logic                         mem_rd_req,
  input  logic                         mem_rd_valid,
  input  logic [SAMPLE_W-1:0]          mem_rd_data,
  output logic                         mem_rd_ack,
  output logic [ADDR_W-1:0]            cur_addr,
  output logic                         busy,
  output logic                         done,
  output logic [OVR_W-1:0]             overrun
);

  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(CHANNELS - 1);

  state_t                       state, state_nxt;
  mode_t                        mode_cap;
  logic [ADDR_W-1:0]            base;
  logic [CH_IDX_W-1:0]          ch_idx;
  logic                         last_ch, mode_active, mode_same, fits;
  logic [ADDR_W:0]              frame_top;
  logic                         enter_active, clear_addr, start_frame, wrap_base, set_done;
  logic                         do_write, do_rd_req, capture, do_rd_ack, frame_done;
  logic                         frame_advance, overrun_inc;
  logic [SAMPLE_W-1:0]          buf_rd_data;
  logic [CHANNELS*SAMPLE_W-1:0] buf_frame;

  assign last_ch     = (ch_idx == LAST_CH);
  assign mode_active = (mode == MODE_REC) || (mode == MODE_PLAY);
  assign mode_same   = (mode_t'(mode) == mode_cap);
  // Widened by one bit so the fit check cannot wrap near the top of memory.
  assign frame_top   = {1'b0, base} + (ADDR_W+1)'(CHANNELS - 1);
  assign fits        = (frame_top <= {1'b0, end_addr});
  assign busy        = (state != S_IDLE);
  assign cur_addr    = base;

  frame_buffer #(
    .SAMPLE_W(SAMPLE_W),
    .CHANNELS(CHANNELS)
  ) u_frame_buffer (
    .clk      (clk),
    .RST      (RST),
    .load_all (start_frame && (mode_cap == MODE_REC)),
    .frame_in (in_samples),
    .wr_en    (capture),
    .wr_idx   (ch_idx),
    .wr_data  (mem_rd_data),
    .rd_idx   (ch_idx),
    .rd_data  (buf_rd_data),
    .frame_out(buf_frame)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (!addr_clr && mode_active && !done) state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME:
        if (!mode_same) begin
          state_nxt = S_IDLE;
        end else if (sample_end) begin
          if (!fits && !loop_en)        state_nxt = S_IDLE;
          else if (mode_cap == MODE_REC) state_nxt = S_WR;
          else                           state_nxt = S_RD_REQ;
        end
      S_WR:      if (mem_rdy && last_ch) state_nxt = S_WAIT_FRAME;
      S_RD_REQ:  if (mem_rdy)            state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (mem_rd_valid)       state_nxt = S_RD_ACK;
      S_RD_ACK:  state_nxt = last_ch ? S_WAIT_FRAME : S_RD_REQ;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    enter_active = 1'b0;
    clear_addr   = 1'b0;
    start_frame  = 1'b0;
    wrap_base    = 1'b0;
    set_done     = 1'b0;
    do_write     = 1'b0;
    do_rd_req    = 1'b0;
    capture      = 1'b0;
    do_rd_ack    = 1'b0;
    frame_done   = 1'b0;
    case (state)
      S_IDLE:
        if (addr_clr)                  clear_addr   = 1'b1;
        else if (mode_active && !done) enter_active = 1'b1;
      S_WAIT_FRAME:
        if (mode_same && sample_end) begin
          if (fits) begin
            start_frame = 1'b1;
          end else if (loop_en) begin
            wrap_base   = 1'b1;
            start_frame = 1'b1;
          end else begin
            set_done = 1'b1;
          end
        end
      S_WR:      do_write  = mem_rdy;
      S_RD_REQ:  do_rd_req = mem_rdy;
      S_RD_WAIT: capture   = mem_rd_valid;
      S_RD_ACK: begin
        do_rd_ack  = 1'b1;
        frame_done = last_ch;
      end
      default: ;
    endcase
  end

  assign frame_advance = (do_write || do_rd_ack) && last_ch;
  // A strobe seen mid-frame cannot be serviced, so it is dropped and counted.
  assign overrun_inc   = sample_end && (state != S_IDLE) && (state != S_WAIT_FRAME);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      mode_cap    <= MODE_IDLE;
      base        <= '0;
      ch_idx      <= '0;
      done        <= 1'b0;
      overrun     <= '0;
      out_samples <= '0;
      out_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_rd_ack  <= 1'b0;
    end else begin
      mem_we     <= do_write;
      mem_rd_req <= do_rd_req;
      mem_rd_ack <= do_rd_ack;
      out_valid  <= frame_done;
      if (do_write || do_rd_req) mem_addr  <= base + ADDR_W'(ch_idx);
      if (do_write)              mem_wdata <= buf_rd_data;
      if (frame_done)            out_samples <= buf_frame;
      if (enter_active)          mode_cap <= mode_t'(mode);

      if (clear_addr || start_frame)  ch_idx <= '0;
      else if (do_write || do_rd_ack) ch_idx <= last_ch ? '0 : ch_idx + 1'b1;

      if (clear_addr || wrap_base) base <= '0;
      else if (frame_advance)      base <= base + ADDR_W'(CHANNELS);

      if (clear_addr || enter_active) done <= 1'b0;
      else if (set_done)              done <= 1'b1;

      if (overrun_inc && (overrun != '1)) overrun <= overrun + 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_ram_sequencer.sv
// Scoreboard bench for audio_ram_sequencer: directed record/play/overrun/reset
// scenarios against a small RAM model with configurable read latency.
module tb_audio_ram_sequencer;

  localparam int SW = 16;
  localparam int CH = 2;
  localparam int AW = 26;
  localparam int OW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              RST = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              loop_en = 1'b0;
  logic              addr_clr = 1'b0;
  logic [AW-1:0]     end_addr = '0;
  logic              sample_end = 1'b0;
  logic [CH*SW-1:0]  in_samples = '0;
  logic [CH*SW-1:0]  out_samples;
  logic              out_valid;
  logic              mem_rdy = 1'b0;
  logic [AW-1:0]     mem_addr;
  logic [SW-1:0]     mem_wdata;
  logic              mem_we;
  logic              mem_rd_req;
  logic              mem_rd_valid = 1'b0;
  logic [SW-1:0]     mem_rd_data = '0;
  logic              mem_rd_ack;
  logic [AW-1:0]     cur_addr;
  logic              busy;
  logic              done;
  logic [OW-1:0]     overrun;

  int checks = 0;
  int errors = 0;
  int rd_lat = 2;
  int rd_cnt = 0;
  logic [3:0]    rd_addr = '0;
  logic [SW-1:0] ram [16];
  wr_t           exp_wr[$];
  logic [CH*SW-1:0] exp_frame[$];

  audio_ram_sequencer #(
    .SAMPLE_W(SW), .CHANNELS(CH), .ADDR_W(AW), .OVR_W(OW)
  ) dut (
    .clk(clk), .RST(RST), .mode(mode), .loop_en(loop_en), .addr_clr(addr_clr),
    .end_addr(end_addr), .sample_end(sample_end), .in_samples(in_samples),
    .out_samples(out_samples), .out_valid(out_valid), .mem_rdy(mem_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rd_req(mem_rd_req), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_rd_ack(mem_rd_ack), .cur_addr(cur_addr), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_frame(input logic [SW-1:0] ch0, input logic [SW-1:0] ch1);
    @(negedge clk);
    in_samples = {ch1, ch0};
    sample_end = 1'b1;
    @(negedge clk);
    sample_end = 1'b0;
  endtask

  task automatic push_wr(input int addr, input logic [SW-1:0] data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = data;
    exp_wr.push_back(e);
  endtask

  // RAM model: read data appears rd_lat cycles after a request, held until acked.
  always @(negedge clk) begin
    if (!RST) begin
      mem_rd_valid = 1'b0;
      rd_cnt = 0;
    end else begin
      if (mem_we) ram[mem_addr[3:0]] = mem_wdata;
      if (mem_rd_ack) mem_rd_valid = 1'b0;
      if (mem_rd_req) begin
        rd_cnt  = rd_lat;
        rd_addr = mem_addr[3:0];
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = ram[rd_addr];
        end
      end
    end
  end

  // Monitor: pops expected writes/frames whenever the DUT presents them.
  always @(negedge clk) begin
    if (RST) begin
      if (mem_we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write actual=%0h:%0h required=none", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL write actual=%0h:%0h required=%0h:%0h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
      end
      if (out_valid) begin
        checks++;
        if (exp_frame.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_frame actual=%0h required=none", out_samples);
        end else begin
          logic [CH*SW-1:0] f;
          f = exp_frame.pop_front();
          if (out_samples !== f) begin
            errors++;
            $display("[TB] FAIL frame actual=%0h required=%0h", out_samples, f);
          end
        end
      end
      if ((int'(mem_we) + int'(mem_rd_req) + int'(mem_rd_ack)) > 1) begin
        checks++;
        errors++;
        $display("[TB] FAIL strobe_exclusive actual=%b%b%b required=onehot",
                 mem_we, mem_rd_req, mem_rd_ack);
      end
    end
  end

  initial begin
    int stall_we;
    for (int i = 0; i < 16; i++) ram[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_value("rst_mem_addr", 64'(mem_addr), 0);
    check_value("rst_strobes", 64'({mem_we, mem_rd_req, mem_rd_ack, out_valid, busy, done}), 0);
    check_value("rst_out_samples", 64'(out_samples), 0);
    check_value("rst_overrun", 64'(overrun), 0);
    RST = 1'b1;

    // Record four frames into 0..7, fifth strobe hits end of buffer
    end_addr = AW'(7);
    mem_rdy  = 1'b1;
    mode     = 2'd1;
    repeat (2) @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      push_wr(2*f,     SW'(16'h1111 * (2*f + 1)));
      push_wr(2*f + 1, SW'(16'h1111 * (2*f + 2)));
      apply_frame(SW'(16'h1111 * (2*f + 1)), SW'(16'h1111 * (2*f + 2)));
      repeat (3) @(negedge clk);
    end
    apply_frame(16'h9999, 16'hAAAA);
    repeat (3) @(negedge clk);
    check_value("rec_done", 64'(done), 1);
    check_value("rec_cur_addr", 64'(cur_addr), 8);
    check_value("rec_busy_after_done", 64'(busy), 0);

    // addr_clr in idle clears base and done
    mode = 2'd0;
    addr_clr = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0;
    @(negedge clk);
    check_value("clr_cur_addr", 64'(cur_addr), 0);
    check_value("clr_done", 64'(done), 0);

    // Record with mem_rdy stalled mid-frame
    mode = 2'd1;
    repeat (2) @(negedge clk);
    push_wr(0, 16'hB000);
    push_wr(1, 16'hB001);
    apply_frame(16'hB000, 16'hB001);
    repeat (3) @(negedge clk);
    push_wr(2, 16'hB002);
    push_wr(3, 16'hB003);
    mem_rdy = 1'b0;
    apply_frame(16'hB002, 16'hB003);
    stall_we = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_we) stall_we++;
    end
    check_value("stall_no_we", 64'(stall_we), 0);
    check_value("stall_busy", 64'(busy), 1);
    mem_rdy = 1'b1;
    repeat (4) @(negedge clk);
    check_value("stall_cur_addr", 64'(cur_addr), 4);

    // addr_clr ignored while waiting for a frame
    addr_clr = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0;
    @(negedge clk);
    check_value("clr_ignored_addr", 64'(cur_addr), 4);
    check_value("clr_ignored_busy", 64'(busy), 1);
    mode = 2'd0;
    repeat (2) @(negedge clk);
    addr_clr = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0;
    @(negedge clk);
    check_value("clr_idle_addr", 64'(cur_addr), 0);
    check_value("clr_idle_busy", 64'(busy), 0);

    // Looped playback over a 4-word buffer
    ram[0] = 16'h00A0; ram[1] = 16'h00A1; ram[2] = 16'h00A2; ram[3] = 16'h00A3;
    end_addr = AW'(3);
    loop_en  = 1'b1;
    rd_lat   = 2;
    mode     = 2'd2;
    repeat (2) @(negedge clk);
    exp_frame.push_back(32'h00A1_00A0);
    exp_frame.push_back(32'h00A3_00A2);
    exp_frame.push_back(32'h00A1_00A0);
    for (int f = 0; f < 3; f++) begin
      apply_frame(16'h0, 16'h0);
      repeat (20) @(negedge clk);
    end
    check_value("play_wrap_cur_addr", 64'(cur_addr), 2);
    check_value("play_overrun", 64'(overrun), 0);

    // Two strobes dropped during a slow read
    rd_lat = 10;
    exp_frame.push_back(32'h00A3_00A2);
    apply_frame(16'h0, 16'h0);
    repeat (2) @(negedge clk);
    apply_frame(16'h0, 16'h0);
    apply_frame(16'h0, 16'h0);
    check_value("ovr_out_hold", 64'(out_samples), 64'h00A1_00A0);
    check_value("ovr_count_mid", 64'(overrun), 2);
    repeat (40) @(negedge clk);
    check_value("ovr_count_final", 64'(overrun), 2);
    check_value("ovr_out_final", 64'(out_samples), 64'h00A3_00A2);

    // Reset asserted after channel 0 of a record frame is written
    loop_en  = 1'b0;
    end_addr = AW'(7);
    mode     = 2'd1;
    repeat (3) @(negedge clk);
    check_value("pre_rst_cur_addr", 64'(cur_addr), 4);
    push_wr(4, 16'hC000);
    apply_frame(16'hC000, 16'hC001);
    @(negedge clk);
    #2 RST = 1'b0;
    #1;
    check_value("async_rst_mem", 64'({mem_addr, mem_wdata}), 0);
    check_value("async_rst_out", 64'(out_samples), 0);
    check_value("async_rst_flags", 64'({mem_we, busy, done, out_valid}), 0);
    repeat (2) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check_value("post_rst_cur_addr", 64'(cur_addr), 0);
    check_value("post_rst_overrun", 64'(overrun), 0);
    @(negedge clk);
    push_wr(0, 16'hD000);
    push_wr(1, 16'hD001);
    apply_frame(16'hD000, 16'hD001);
    repeat (4) @(negedge clk);
    check_value("post_rst_base_adv", 64'(cur_addr), 2);

    check_value("wr_queue_empty", 64'(exp_wr.size()), 0);
    check_value("frame_queue_empty", 64'(exp_frame.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_ram_sequencer.md
Name: audio_ram_sequencer

Overview:
Parametrised record/playback sequencer that moves multi-channel audio frames between the codec sample path and the DDR memory interface. It replaces the single-channel ad-hoc RAM FSM in the controller. It adds configurable channel count and sample width, a loop mode, overrun detection, end-of-buffer handling and frame-atomic playback output. It sits between the audio interface (sample_end strobe, sample buses) and the mem_interface user port.

Parameters:
SAMPLE_W, 16, bits per audio sample; equals the RAM word width.
CHANNELS, 2, channels per frame; each sample occupies one RAM word (1..8).
ADDR_W, 26, RAM word address width.
OVR_W, 8, overrun counter width (saturating).

Ports:
clk  in  1  system clock (50 MHz domain)
RST  in  1  asynchronous, active-low reset
mode  in  2  0=idle, 1=record, 2=play, 3=reserved (treated as idle)
loop_en  in  1  wrap to address 0 at end of buffer instead of stopping
addr_clr  in  1  clear address pointer; honoured only in S_IDLE
end_addr  in  ADDR_W  last usable RAM word address
sample_end  in  1  one-cycle frame strobe from codec path
in_samples  in  CHANNELS*SAMPLE_W  record frame; ch0 in LSBs
out_samples  out  CHANNELS*SAMPLE_W  playback frame, registered
out_valid  out  1  one-cycle pulse when out_samples updates
mem_rdy  in  1  memory interface ready (status)
mem_addr  out  ADDR_W  word address
mem_wdata  out  SAMPLE_W  write data
mem_we  out  1  one-cycle write pulse
mem_rd_req  out  1  one-cycle read request pulse
mem_rd_valid  in  1  read data present
mem_rd_data  in  SAMPLE_W  read data
mem_rd_ack  out  1  one-cycle acknowledge of read data
cur_addr  out  ADDR_W  current frame base address
busy  out  1  high whenever state is not S_IDLE
done  out  1  sticky flag: end of buffer reached with loop_en=0; cleared by addr_clr or a new mode entry from idle
overrun  out  OVR_W  saturating count of dropped frame strobes

Behaviour:
- Reset (RST=0, async): all outputs 0, state S_IDLE, base address 0, channel index 0, overrun 0, done 0.
- States: S_IDLE, S_WAIT_FRAME, S_WR, S_RD_REQ, S_RD_WAIT, S_RD_ACK.
- S_IDLE: if addr_clr, set base=0 and done=0. Else if mode is 1 or 2 and done=0, go to S_WAIT_FRAME.
- S_WAIT_FRAME:
  - If mode is not the captured mode: go to S_IDLE.
  - On sample_end: check the fit rule (base+CHANNELS-1 <= end_addr).
  - Frame does not fit, loop_en=0: set done, go to S_IDLE, no RAM access.
  - Frame does not fit, loop_en=1: base=0, then proceed in the same cycle.
  - Record: latch in_samples and go to S_WR. Play: go to S_RD_REQ.
- S_WR: for each channel k=0..CHANNELS-1, wait for mem_rdy=1. Then drive mem_addr=base+k and mem_wdata=sample k, pulse mem_we for exactly one cycle. After the last channel, base+=CHANNELS and return to S_WAIT_FRAME.
- S_RD_REQ: wait for mem_rdy, then pulse mem_rd_req with mem_addr=base+k, go to S_RD_WAIT.
- S_RD_WAIT: when mem_rd_valid=1, capture mem_rd_data into shadow slot k and go to S_RD_ACK.
- S_RD_ACK: pulse mem_rd_ack for one cycle.
  - If k is not the last channel: k+1, go to S_RD_REQ.
  - If k is the last channel: copy the shadow frame to out_samples, pulse out_valid in the same cycle, base+=CHANNELS, go to S_WAIT_FRAME.
- Overrun: a sample_end arriving in any state other than S_WAIT_FRAME (while busy) increments overrun, saturating at all-ones. The frame is dropped and out_samples holds its value.
- Mode change mid-frame: the current frame completes all channels first; the new mode is checked in S_WAIT_FRAME.
- mem_addr, mem_wdata hold their last values when no strobe is active. Only one of mem_we / mem_rd_req / mem_rd_ack is ever high in a cycle.
- Address arithmetic: ADDR_W bits, no overflow beyond end_addr because of the fit rule.
- Latency: minimum record frame = 1 + CHANNELS cycles from sample_end with mem_rdy constantly high. Play frame = 1 + 3*CHANNELS cycles plus read latency per channel.

Decomposition:
- Shared package audio_mem_pkg holds the mode encodings (MODE_IDLE/REC/PLAY), state encodings, and default widths.
- A natural sub-module is frame_buffer, a CHANNELS x SAMPLE_W register array with indexed write and parallel read. It serves as both the record latch and the playback shadow.

Test Plan:
- Record, CHANNELS=2, end_addr=7, mem_rdy=1, four sample_end strobes with frames {0x1111,0x2222}..{0x7777,0x8888} -> writes to addresses 0..7 in order; fifth strobe sets done=1 with no mem_we; cur_addr=8.
- Play with loop_en=1, end_addr=3, RAM preloaded 0xA0..0xA3 -> out_samples alternates {0xA1,0xA0} and {0xA3,0xA2} with one out_valid per frame; base wraps to 0.
- mem_rdy held low for 5 cycles mid-record -> mem_we stalls, no write lost or duplicated; address sequence unchanged.
- sample_end pulsed twice while in S_RD_WAIT with 10-cycle read latency -> overrun=2; out_samples unchanged until the frame completes.
- RST asserted during S_WR after channel 0 has been written -> all outputs 0 immediately; after release, addr_clr is not needed and base=0.
- addr_clr pulsed while mode=1 in S_WAIT_FRAME -> ignored; after mode=0 and addr_clr -> cur_addr=0, done=0.
